// File: rtl/out_buffer_pkg.sv
// -----------------------------------------------------------------------------
// out_buffer_pkg
// Shared definitions for the frame output buffer: the frame-control state
// encoding and the buffering-mode constants used by the MODE parameter.
// -----------------------------------------------------------------------------
package out_buffer_pkg;

  // Store-and-forward frame control: FILL accepts one frame upstream, DRAIN
  // presents it downstream.
  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Buffering modes selected by the MODE parameter.
  localparam int MODE_SAF = 0;  // store-and-forward: whole frame in, then out
  localparam int MODE_CT  = 1;  // cut-through: plain FIFO, no frame gating

endpackage

// File: rtl/sync_fifo_fwft.sv
// -----------------------------------------------------------------------------
// sync_fifo_fwft
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// rd_data whenever the FIFO is not empty; rd_en pops it.
//
// Ports
//   clk      : clock, all logic on the rising edge
//   rst_n    : synchronous active-low reset (pointers and count only)
//   wr_en    : push wr_data (ignored when full)
//   wr_data  : entry to push
//   rd_en    : pop the head entry (ignored when empty)
//   rd_data  : head entry
//   full     : count == DEPTH
//   empty    : count == 0
//   count    : occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo_fwft #(
  parameter int WIDTH = 257,
  parameter int DEPTH = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   COUNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_fire;
  logic             rd_fire;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  // Guarding here makes overflow and underflow impossible regardless of caller.
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: the storage array is deliberately not reset; clearing the pointers
  // and count already discards its contents, and a reset on a RAM would stop
  // it mapping onto memory macros.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      // A simultaneous push and pop leaves the occupancy unchanged.
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frame_out_buffer.sv
// -----------------------------------------------------------------------------
// frame_out_buffer
// Frame-aware output buffer in front of a downstream sink. Each entry holds a
// payload beat plus its last tag.
//   MODE_SAF : a whole frame is collected (FILL) before any of it is presented
//              downstream (DRAIN). A frame that would overrun the buffer is cut
//              at DEPTH beats: the DEPTH-th beat is tagged last, Err_Oversize
//              sets, and the remaining upstream beats become the next frame.
//   MODE_CT  : plain first-word-fall-through FIFO, frames pass through.
//
// Ports
//   clk          : clock, all logic on the rising edge
//   rst          : synchronous active-low reset
//   S_Data       : upstream beat payload
//   S_Valid      : upstream beat valid
//   S_Ready      : buffer accepts an upstream beat
//   S_Last       : final beat of the upstream frame
//   M_Data       : downstream beat payload (head entry)
//   M_Valid      : downstream beat valid
//   M_Ready      : downstream accepts a beat
//   M_Last       : last tag of the head entry
//   Count        : buffer occupancy, 0..DEPTH
//   Frame_Done   : one-cycle pulse after a last-tagged beat leaves
//   Err_Oversize : sticky, a store-and-forward frame was cut at DEPTH beats
// -----------------------------------------------------------------------------
module frame_out_buffer
  import out_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 4096,
  parameter int MODE       = MODE_SAF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   S_Data,
  input  logic                    S_Valid,
  output logic                    S_Ready,
  input  logic                    S_Last,
  output logic [DATA_WIDTH-1:0]   M_Data,
  output logic                    M_Valid,
  input  logic                    M_Ready,
  output logic                    M_Last,
  output logic [$clog2(DEPTH):0]  Count,
  output logic                    Frame_Done,
  output logic                    Err_Oversize
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Occupancy at which the next accepted beat fills the last free slot.
  localparam logic [CW-1:0] LAST_SLOT = CW'(DEPTH - 1);
  localparam bit            SAF       = (MODE == MODE_SAF);

  state_t                state;
  logic                  full;
  logic                  empty;
  logic [DATA_WIDTH:0]   head;
  logic                  head_last;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  wr_last;

  // Handshakes are gated with rst itself so both sides are quiet for the
  // whole reset, including the cycle before the first reset edge, and the
  // buffer is ready again as soon as reset is released.
  assign S_Ready = rst && !full  && (!SAF || state == FILL);
  assign M_Valid = rst && !empty && (!SAF || state == DRAIN);

  assign wr_fire = S_Valid && S_Ready;
  assign rd_fire = M_Valid && M_Ready;

  // In store-and-forward the beat landing in the last free slot must close
  // the frame, otherwise FILL would stall forever on a full buffer.
  assign wr_last = S_Last || (SAF && Count == LAST_SLOT);

  assign head_last = head[DATA_WIDTH];
  assign M_Data    = head[DATA_WIDTH-1:0];
  // The stale head of an empty buffer must never look like a frame end.
  assign M_Last    = rst && !empty && head_last;

  sync_fifo_fwft #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .wr_en   (wr_fire),
    .wr_data ({wr_last, S_Data}),
    .rd_en   (rd_fire),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (Count)
  );

  // Frame control. In cut-through the state stays in FILL and only
  // Frame_Done is produced.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= FILL;
      Frame_Done   <= 1'b0;
      Err_Oversize <= 1'b0;
    end else begin
      Frame_Done <= rd_fire && head_last;
      if (SAF) begin
        case (state)
          FILL: begin
            if (wr_fire && wr_last) begin
              state <= DRAIN;
              // Closed by the buffer filling up rather than by the source.
              if (!S_Last) begin
                Err_Oversize <= 1'b1;
              end
            end
          end
          DRAIN: begin
            // Only one frame is ever held, so its last beat empties the buffer.
            if (rd_fire && head_last) begin
              state <= FILL;
            end
          end
          default: state <= FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_out_buffer.sv
// -----------------------------------------------------------------------------
// tb_frame_out_buffer
// Two instances (store-and-forward and cut-through, DEPTH 16) share the
// upstream/downstream stimulus; only the selected one is out of reset. A
// queue-level reference model predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_frame_out_buffer;

  localparam int DW = 32;
  localparam int D  = 16;
  localparam int CW = $clog2(D) + 1;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          cur;      // 0: store-and-forward instance, 1: cut-through
  logic          rst_drv;
  logic          rst_saf;
  logic          rst_ct;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_last;
  logic          m_ready;

  logic          saf_s_ready, saf_m_valid, saf_m_last, saf_done, saf_err;
  logic [DW-1:0] saf_m_data;
  logic [CW-1:0] saf_count;
  logic          ct_s_ready, ct_m_valid, ct_m_last, ct_done, ct_err;
  logic [DW-1:0] ct_m_data;
  logic [CW-1:0] ct_count;

  assign rst_saf = cur ? 1'b0 : rst_drv;
  assign rst_ct  = cur ? rst_drv : 1'b0;

  frame_out_buffer #(.DATA_WIDTH(DW), .DEPTH(D), .MODE(0)) u_saf (
    .clk(clk), .rst(rst_saf),
    .S_Data(s_data), .S_Valid(s_valid), .S_Ready(saf_s_ready), .S_Last(s_last),
    .M_Data(saf_m_data), .M_Valid(saf_m_valid), .M_Ready(m_ready), .M_Last(saf_m_last),
    .Count(saf_count), .Frame_Done(saf_done), .Err_Oversize(saf_err)
  );

  frame_out_buffer #(.DATA_WIDTH(DW), .DEPTH(D), .MODE(1)) u_ct (
    .clk(clk), .rst(rst_ct),
    .S_Data(s_data), .S_Valid(s_valid), .S_Ready(ct_s_ready), .S_Last(s_last),
    .M_Data(ct_m_data), .M_Valid(ct_m_valid), .M_Ready(m_ready), .M_Last(ct_m_last),
    .Count(ct_count), .Frame_Done(ct_done), .Err_Oversize(ct_err)
  );

  logic          dut_s_ready, dut_m_valid, dut_m_last, dut_done, dut_err;
  logic [DW-1:0] dut_m_data;
  logic [CW-1:0] dut_count;

  assign dut_s_ready = cur ? ct_s_ready : saf_s_ready;
  assign dut_m_valid = cur ? ct_m_valid : saf_m_valid;
  assign dut_m_last  = cur ? ct_m_last  : saf_m_last;
  assign dut_done    = cur ? ct_done    : saf_done;
  assign dut_err     = cur ? ct_err     : saf_err;
  assign dut_m_data  = cur ? ct_m_data  : saf_m_data;
  assign dut_count   = cur ? ct_count   : saf_count;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] actual,
                       input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  beat_t         mq[$];    // buffer contents, head first
  beat_t         src[$];   // beats still waiting upstream
  bit            draining; // store-and-forward: a complete frame is held
  bit            err_m;
  bit            done_m;
  bit            hold_pending;
  logic [DW-1:0] held_data;
  int            done_seen;

  task automatic model_reset();
    mq.delete();
    draining     = 1'b0;
    err_m        = 1'b0;
    done_m       = 1'b0;
    hold_pending = 1'b0;
  endtask

  function automatic bit exp_s_ready();
    if (!rst_drv || mq.size() >= D) return 1'b0;
    return cur || !draining;
  endfunction

  function automatic bit exp_m_valid();
    if (!rst_drv || mq.size() == 0) return 1'b0;
    return cur || draining;
  endfunction

  task automatic compare_outputs();
    bit ev;
    ev = exp_m_valid();
    check("s_ready", dut_s_ready, exp_s_ready());
    check("m_valid", dut_m_valid, ev);
    check("count", dut_count, mq.size());
    check("frame_done", dut_done, done_m);
    check("err_oversize", dut_err, err_m);
    if (ev) begin
      check("m_data", dut_m_data, mq[0].data);
      check("m_last", dut_m_last, mq[0].last);
    end else if (!rst_drv) begin
      check("m_last_in_reset", dut_m_last, 1'b0);
    end
    if (hold_pending && dut_m_valid) begin
      check("m_data_hold", dut_m_data, held_data);
    end
    if (dut_done) done_seen++;
  endtask

  task automatic advance();
    bit    wr;
    bit    rd;
    beat_t b;
    if (!rst_drv) begin
      model_reset();
      return;
    end
    wr = s_valid && exp_s_ready();
    rd = m_ready && exp_m_valid();
    hold_pending = dut_m_valid && !m_ready;
    held_data    = dut_m_data;
    done_m       = rd && mq[0].last;
    if (rd) begin
      if (!cur && mq[0].last) draining = 1'b0;
      void'(mq.pop_front());
    end
    if (wr) begin
      b = src[0];
      void'(src.pop_front());
      // A store-and-forward frame reaching D beats is closed by the buffer.
      if (!cur && !b.last && mq.size() == D - 1) begin
        b.last = 1'b1;
        err_m  = 1'b1;
      end
      mq.push_back(b);
      if (!cur && b.last) draining = 1'b1;
    end
  endtask

  // One clock: drive inputs after the rising edge, check at the falling edge.
  task automatic cycle(input bit want_valid, input bit ready);
    s_valid = want_valid && (src.size() > 0);
    if (s_valid) begin
      s_data = src[0].data;
      s_last = src[0].last;
    end else begin
      s_data = '0;
      s_last = 1'b0;
    end
    m_ready = ready;
    @(negedge clk);
    compare_outputs();
    advance();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = $urandom();
      b.last = (i == len - 1);
      src.push_back(b);
    end
  endtask

  task automatic run(input int valid_pct, input int ready_pct, input int budget);
    int n;
    n = 0;
    while ((src.size() > 0 || mq.size() > 0) && n < budget) begin
      cycle($urandom_range(0, 99) < valid_pct, $urandom_range(0, 99) < ready_pct);
      n++;
    end
    check("drain_timeout", src.size() + mq.size(), 0);
    repeat (2) cycle(1'b0, 1'b1);
  endtask

  task automatic do_reset(input int n);
    rst_drv = 1'b0;
    repeat (n) cycle(1'b0, 1'b0);
    rst_drv = 1'b1;
  endtask

  initial begin
    int n;
    int pushed;
    cur     = 1'b0;
    rst_drv = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    done_seen = 0;

    // Store-and-forward: reset state, then a 5-beat frame.
    do_reset(3);
    done_seen = 0;
    push_frame(5);
    run(100, 100, 100);
    check("saf_5beat_frames", done_seen, 1);

    // 20-beat frame: cut at 16, remainder forms a second frame.
    done_seen = 0;
    push_frame(20);
    run(100, 100, 200);
    check("saf_oversize_frames", done_seen, 2);
    check("saf_oversize_err", dut_err, 1'b1);

    // Random handshakes over ~100 beats in frames of 1..20 beats.
    pushed = 0;
    while (pushed < 100) begin
      n = $urandom_range(1, 20);
      push_frame(n);
      pushed += n;
    end
    run(70, 50, 3000);

    // Reset while draining a held 3-beat frame.
    push_frame(3);
    n = 0;
    while (!(draining && mq.size() == 3) && n < 50) begin
      cycle(1'b1, 1'b0);
      n++;
    end
    check("saf_held_count", dut_count, 3);
    repeat (3) cycle(1'b0, 1'b0);
    done_seen = 0;
    rst_drv   = 1'b0;
    repeat (2) cycle(1'b0, 1'b1);
    rst_drv = 1'b1;
    repeat (4) cycle(1'b0, 1'b1);
    check("saf_reset_no_done", done_seen, 0);

    // Switch to the cut-through instance.
    rst_drv = 1'b0;
    cur     = 1'b1;
    model_reset();
    src.delete();
    do_reset(3);

    // Continuous flow: occupancy settles at one entry.
    push_frame(30);
    repeat (10) cycle(1'b1, 1'b1);
    check("ct_steady_count", dut_count, 1);
    run(100, 100, 100);

    // Fill to full with the sink stalled, then drain.
    push_frame(20);
    repeat (20) cycle(1'b1, 1'b0);
    check("ct_full_s_ready", dut_s_ready, 1'b0);
    check("ct_full_count", dut_count, D);
    run(100, 100, 200);

    // Random handshakes over ~100 beats.
    pushed = 0;
    while (pushed < 100) begin
      n = $urandom_range(1, 12);
      push_frame(n);
      pushed += n;
    end
    run(60, 50, 3000);
    check("ct_err_never", dut_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/frame_out_buffer.md
FRAME_OUT_BUFFER -- requirements
Module: frame_out_buffer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 256, meaning payload width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4096, meaning FIFO entries (power of two, >=4).
REQ-003 The block SHALL have parameter MODE, default 0, meaning 0 = store-and-forward, 1 = cut-through.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: one clock; reset is synchronous and active-low (rst=0 resets).
REQ-006 The block SHALL have port S_Data, input, DATA_WIDTH bits: upstream beat payload.
REQ-007 The block SHALL have port S_Valid, input, 1 bit: upstream beat valid.
REQ-008 The block SHALL have port S_Ready, output, 1 bit: block accepts a beat.
REQ-009 The block SHALL have port S_Last, input, 1 bit: final beat of frame, qualified by S_Valid.
REQ-010 The block SHALL have port M_Data, output, DATA_WIDTH bits: downstream beat payload.
REQ-011 The block SHALL have port M_Valid, output, 1 bit: downstream beat valid.
REQ-012 The block SHALL have port M_Ready, input, 1 bit: downstream accepts a beat.
REQ-013 The block SHALL have port M_Last, output, 1 bit: final beat of frame, qualified by M_Valid.
REQ-014 The block SHALL have port Count, output, $clog2(DEPTH)+1 bits: current FIFO occupancy.
REQ-015 The block SHALL have port Frame_Done, output, 1 bit: one-cycle pulse when a frame's last beat leaves.
REQ-016 The block SHALL have port Err_Oversize, output, 1 bit: sticky flag, a MODE 0 frame exceeded DEPTH.

Function
REQ-017 The block SHALL transfer a beat on each side only in cycles where Valid and Ready are both 1.
REQ-018 The block SHALL store DATA_WIDTH+1 bits per entry: payload plus a last tag.
REQ-019 The block SHALL present the head entry first-word-fall-through: M_Data and M_Last are valid whenever M_Valid=1.
REQ-020 The block SHALL hold M_Data and M_Last stable while M_Valid=1 and M_Ready=0.
REQ-021 In MODE 0, the block SHALL implement the states FILL and DRAIN.
REQ-022 In FILL, S_Ready SHALL equal !full and M_Valid SHALL be 0.
REQ-023 In DRAIN, S_Ready SHALL be 0 and M_Valid SHALL equal !empty.
REQ-024 In MODE 0, a FILL to DRAIN transition SHALL occur on the cycle after an accepted beat with S_Last=1.
REQ-025 In MODE 0, if an accepted beat brings Count to DEPTH with S_Last=0, the beat SHALL be tagged last, Err_Oversize SHALL set, and the state SHALL go to DRAIN.
REQ-026 The beats of an oversize frame that remain upstream SHALL form the next frame.
REQ-027 A DRAIN to FILL transition SHALL occur on the cycle after the tagged-last beat is accepted downstream.
REQ-028 In MODE 1, S_Ready SHALL equal !full and M_Valid SHALL equal !empty at all times, with no state machine and no oversize condition.
REQ-029 Write-to-output latency: in MODE 1, M_Valid SHALL rise 1 cycle after the first write into an empty FIFO.
REQ-030 Write-to-output latency: in MODE 0, M_Valid SHALL rise 1 cycle after entering DRAIN.
REQ-031 M_Last SHALL equal the head entry's last tag.
REQ-032 Frame_Done SHALL be 1 for exactly the cycle after a beat with M_Last=1 is accepted downstream.
REQ-033 Count SHALL increment on a write only, decrement on a read only, and stay unchanged on a simultaneous write and read.
REQ-034 Count SHALL never wrap; writes at full and reads at empty are impossible by construction.
REQ-035 The read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-036 While rst=0 at a clock edge, the state SHALL go to FILL, pointers and Count SHALL go to 0, and stored data SHALL be discarded.
REQ-037 During reset, S_Ready, M_Valid, M_Last, Frame_Done and Err_Oversize SHALL all be 0.
REQ-038 On the first cycle after reset release, S_Ready SHALL be 1 and Err_Oversize SHALL be cleared; reset is the only way to clear it.
REQ-039 A reset mid-frame SHALL drop any partial frame and produce no Frame_Done.

Structure
REQ-040 Package out_buffer_pkg SHALL hold the state encoding (FILL=1'b0, DRAIN=1'b1) and the MODE constants MODE_SAF=0 and MODE_CT=1.
REQ-041 Storage SHALL be one sub-module, sync_fifo_fwft, parameterised (WIDTH, DEPTH) and providing full, empty and count.
REQ-042 The frame control (state, tag forcing, Frame_Done, Err_Oversize) SHALL reside in frame_out_buffer.

Verification
REQ-043 MODE 0, DEPTH 16, a 5-beat frame D0..D4 with S_Last on D4 and M_Ready=1 -> M_Valid=0 during the write, then D0..D4 on consecutive cycles, M_Last on D4 only, one Frame_Done pulse, S_Ready returns to 1.
REQ-044 MODE 0, DEPTH 16, a 20-beat frame -> S_Ready drops after beat 16, beat 16 has M_Last, Err_Oversize=1, and beats 17..20 drain as a second frame ending with M_Last on beat 20.
REQ-045 MODE 1, continuous S_Valid and M_Ready -> M_Valid one cycle after the first write, and Count stays constant (1) through simultaneous read/write.
REQ-046 M_Ready toggled randomly for 100 beats -> output order and data are exact, and M_Data is stable whenever M_Valid=1 and M_Ready=0.
REQ-047 rst=0 asserted in DRAIN with 3 beats held -> Count=0, M_Valid=0, no Frame_Done, and S_Ready=1 on the first cycle after release.
